bin2bcd_seq: RTL and testbench
==============================

// Module: bin2bcd_seq
// PURPOSE
//   Iterative (shift-add-3) binary-to-BCD converter placed between the binary
//   event counter and the sseg display driver so the 4-digit display shows
//   decimal instead of hex. Accepts one W-bit value per valid/ready handshake
//   and produces D packed BCD digits, a leading-zero blank mask, and an
//   overflow flag after a fixed latency.
// PARAMETERS
//   W  16  binary input width, >= 4
//   D  4   number of BCD digits produced; bcd width is 4*D
// PORTS
//   clk        in   1    system clock (10 MHz domain); all logic posedge
//   rst        in   1    synchronous, active-high reset
//   in_valid   in   1    bin holds a value to convert
//   bin        in   W    unsigned binary input, sampled only on accept edge
//   in_ready   out  1    converter idle, can accept
//   out_valid  out  1    one-cycle pulse: bcd/blank/ovf just updated
//   bcd        out  4*D  result; digit i = bcd[4i+3:4i], digit 0 least significant
//   blank      out  D    bit i=1: digit i and all higher digits are zero (bit 0 always 0)
//   ovf        out  1    last converted value >= 10^D
// BEHAVIOUR
//   - States: IDLE, CONV, DONE. in_ready = (state==IDLE), combinational from state.
//   - Accept: edge with rst=0, state=IDLE, in_valid=1. Latch bin into shift reg,
//     clear scratch BCD and overflow accumulator, load bit counter = W, go CONV.
//   - CONV, one bit per edge, W edges: every scratch digit >= 5 gets +3, then
//     {ovf_acc, digits, shift} shift left 1. ovf_acc |= bit shifted out of top
//     digit, sticky. After the W-th shift go DONE.
//   - DONE (one edge): bcd <= ovf_acc ? all digits 9 : scratch; ovf <= ovf_acc;
//     blank computed from the value written to bcd; out_valid=1 for that cycle;
//     next edge state IDLE.
//   - Latency: out_valid high in the cycle starting W+1 edges after the accept
//     edge (W=16: 17 edges). bcd/blank/ovf hold until the next DONE.
//   - Throughput: one conversion per W+2 cycles; in_ready low in CONV and DONE.
//   - in_valid while in_ready=0: ignored, not queued; bin changes after
//     accept do not affect the result.
//   - Digit adjust uses 4-bit arithmetic; no digit exceeds 9 when bcd is written.
//   - Overflow: saturate to 9...9, ovf=1, blank=0. ovf clears on the next
//     non-overflowing result.
//   - Reset (any state, incl. mid-CONV): state=IDLE, bcd=0, ovf=0,
//     out_valid=0, blank={D-1{1},1'b0}, scratch cleared; aborted conversion
//     never produces out_valid. in_valid while rst=1 is ignored; in_ready=1
//     in the first cycle after reset is released.
// TESTING
//   1 reset -> bcd=16'h0000, blank=4'b1110, ovf=0, out_valid=0, in_ready=1
//   2 bin=1234 accept -> out_valid exactly 17 edges later for one cycle,
//     bcd=16'h1234, blank=4'b0000, ovf=0; in_ready low during those 17 edges
//   3 bin=0 -> 16'h0000/blank 1110; bin=10 -> 16'h0010/blank 1100;
//     bin=9999 -> 16'h9999/blank 0000/ovf 0
//   4 bin=10000 -> bcd=16'h9999, ovf=1, blank=0; then bin=65535 -> same;
//     then bin=7 -> 16'h0007, ovf=0, blank 1110
//   5 in_valid held high, bin changed to 42 mid-CONV -> first result
//     unaffected, 42 accepted on first idle edge; accepts spaced 18 cycles
//   6 rst pulse 5 edges into CONV of bin=500 -> no out_valid, outputs at reset
//     values; next bin=321 -> bcd=16'h0321, blank=4'b1000
//   - Also: randomized bin 0..65535 vs. reference model (sat at 9999 for D=4)

Source files
------------

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to packed BCD converter with
// leading-zero blank mask and saturating overflow.
module bin2bcd_seq #(
   parameter int W = 16,
   parameter int D = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   input  logic [W-1:0]   bin,
   output logic           in_ready,
   output logic           out_valid,
   output logic [4*D-1:0] bcd,
   output logic [D-1:0]   blank,
   output logic           ovf
);

   localparam int CW = $clog2(W + 1);

   typedef enum logic [1:0] {
      IDLE,
      CONV,
      DONE
   } state_t;

   state_t         state;
   logic [W-1:0]   shift_q;
   logic [4*D-1:0] scratch_q;
   logic [4*D-1:0] adj;
   logic [4*D-1:0] result;
   logic           ovf_acc;
   logic [CW-1:0]  cnt_q;

   function automatic logic [D-1:0] blank_of(
      input logic [4*D-1:0] v
   );
      logic [D-1:0] m;
      logic         z;
      m = '0;
      z = 1'b1;
      for (int i = D - 1; i >= 1; i--) begin
         z    = z & (v[4*i +: 4] == 4'd0);
         m[i] = z;
      end
      return m;
   endfunction

   always_comb begin
      adj = '0;
      for (int i = 0; i < D; i++) begin
         if (scratch_q[4*i +: 4] >= 4'd5)
            adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
         else
            adj[4*i +: 4] = scratch_q[4*i +: 4];
      end
   end

   // Any bit lost off the top digit means value >= 10^D
   always_comb begin
      result = ovf_acc ? {D{4'h9}} : scratch_q;
   end

   assign in_ready = (state == IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         shift_q   <= '0;
         scratch_q <= '0;
         ovf_acc   <= 1'b0;
         cnt_q     <= '0;
         bcd       <= '0;
         blank     <= {{(D-1){1'b1}}, 1'b0};
         ovf       <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  shift_q   <= bin;
                  scratch_q <= '0;
                  ovf_acc   <= 1'b0;
                  cnt_q     <= CW'(W);
                  state     <= CONV;
               end
            end
            CONV: begin
               ovf_acc   <= ovf_acc | adj[4*D-1];
               scratch_q <= {adj[4*D-2:0], shift_q[W-1]};
               shift_q   <= {shift_q[W-2:0], 1'b0};
               cnt_q     <= cnt_q - 1'b1;
               if (cnt_q == CW'(1))
                  state <= DONE;
            end
            DONE: begin
               bcd       <= result;
               blank     <= blank_of(result);
               ovf       <= ovf_acc;
               out_valid <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed and random checks for bin2bcd_seq (W=16, D=4).
module tb_bin2bcd_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [15:0] bin;
   logic        in_ready;
   logic        out_valid;
   logic [15:0] bcd;
   logic [3:0]  blank;
   logic        ovf;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   bin2bcd_seq #(.W(16), .D(4)) dut (
      .clk(clk),
      .rst(rst),
      .in_valid(in_valid),
      .bin(bin),
      .in_ready(in_ready),
      .out_valid(out_valid),
      .bcd(bcd),
      .blank(blank),
      .ovf(ovf)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] ref_bcd(input int v);
      logic [15:0] r;
      int          t;
      if (v > 9999) return 16'h9999;
      t = v;
      r = '0;
      for (int i = 0; i < 4; i++) begin
         r[4*i +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   function automatic logic [3:0] ref_blank(input logic [15:0] r);
      logic [3:0] m;
      logic       z;
      m = '0;
      z = 1'b1;
      for (int i = 3; i >= 1; i--) begin
         z    = z & (r[4*i +: 4] == 4'd0);
         m[i] = z;
      end
      return m;
   endfunction

   // Drives one accept, waits for the result; lat=0 on timeout
   task automatic convert(
      input  logic [15:0] v,
      output logic [15:0] rb,
      output logic [3:0]  rbl,
      output logic        ro,
      output int          lat,
      output logic        busy_ok
   );
      busy_ok  = 1'b1;
      lat      = 0;
      in_valid = 1'b1;
      bin      = v;
      step();
      in_valid = 1'b0;
      bin      = ~v;
      if (in_ready) busy_ok = 1'b0;
      for (int n = 1; n <= 40; n++) begin
         step();
         if (out_valid) begin
            lat = n;
            break;
         end
         if (in_ready) busy_ok = 1'b0;
      end
      rb  = bcd;
      rbl = blank;
      ro  = ovf;
   endtask

   task automatic test_reset();
      rst      = 1'b1;
      in_valid = 1'b1;
      bin      = 16'd5;
      repeat (3) step();
      rst      = 1'b0;
      in_valid = 1'b0;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready: got %b, expected 1", in_ready);
      end
      checks++;
      if (bcd !== 16'h0000) begin
         errors++;
         $display("FAIL reset_bcd: got %h, expected 0000", bcd);
      end
      checks++;
      if (blank !== 4'b1110) begin
         errors++;
         $display("FAIL reset_blank: got %b, expected 1110", blank);
      end
      checks++;
      if (ovf !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags: got ovf=%b ov=%b, expected 0 0",
                  ovf, out_valid);
      end
   endtask

   task automatic test_latency();
      logic [15:0] rb;
      logic [3:0]  rbl;
      logic        ro;
      int          lat;
      logic        bok;
      convert(16'd1234, rb, rbl, ro, lat, bok);
      checks++;
      if (lat !== 17) begin
         errors++;
         $display("FAIL lat_1234: got %0d, expected 17", lat);
      end
      checks++;
      if (bok !== 1'b1) begin
         errors++;
         $display("FAIL busy_1234: got ready-high, expected low");
      end
      checks++;
      if (rb !== 16'h1234 || rbl !== 4'b0000 || ro !== 1'b0) begin
         errors++;
         $display("FAIL res_1234: got %h/%b/%b, expected 1234/0000/0",
                  rb, rbl, ro);
      end
      step();
      checks++;
      if (out_valid !== 1'b0 || bcd !== 16'h1234) begin
         errors++;
         $display("FAIL pulse_1234: got ov=%b bcd=%h, expected 0/1234",
                  out_valid, bcd);
      end
   endtask

   task automatic test_table();
      logic [15:0] vals [7]  = '{16'd0, 16'd10, 16'd9999, 16'd10000,
                                 16'd65535, 16'd7, 16'd9};
      logic [15:0] eb   [7]  = '{16'h0000, 16'h0010, 16'h9999, 16'h9999,
                                 16'h9999, 16'h0007, 16'h0009};
      logic [3:0]  ebl  [7]  = '{4'b1110, 4'b1100, 4'b0000, 4'b0000,
                                 4'b0000, 4'b1110, 4'b1110};
      logic        eo   [7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      logic [15:0] rb;
      logic [3:0]  rbl;
      logic        ro;
      int          lat;
      logic        bok;
      for (int k = 0; k < 7; k++) begin
         convert(vals[k], rb, rbl, ro, lat, bok);
         checks++;
         if (rb !== eb[k] || rbl !== ebl[k] || ro !== eo[k]
             || lat !== 17) begin
            errors++;
            $display("FAIL table_%0d: got %h/%b/%b lat %0d, expected %h/%b/%b lat 17",
                     vals[k], rb, rbl, ro, lat, eb[k], ebl[k], eo[k]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] got1;
      int          lat1;
      int          acc2;
      logic [15:0] rb;
      logic [3:0]  rbl;
      int          lat2;
      lat1     = 0;
      acc2     = 0;
      lat2     = 0;
      got1     = '0;
      in_valid = 1'b1;
      bin      = 16'd1234;
      step();
      for (int n = 1; n <= 40; n++) begin
         step();
         if (n == 5) bin = 16'd42;
         if (out_valid && lat1 == 0) begin
            lat1 = n;
            got1 = bcd;
         end
         if (in_ready) begin
            acc2 = n + 1;
            break;
         end
      end
      step();
      in_valid = 1'b0;
      for (int n = 1; n <= 40; n++) begin
         step();
         if (out_valid) begin
            lat2 = n;
            break;
         end
      end
      rb  = bcd;
      rbl = blank;
      checks++;
      if (lat1 !== 17 || got1 !== 16'h1234) begin
         errors++;
         $display("FAIL b2b_first: got %h lat %0d, expected 1234 lat 17",
                  got1, lat1);
      end
      checks++;
      if (acc2 !== 18) begin
         errors++;
         $display("FAIL b2b_spacing: got %0d, expected 18", acc2);
      end
      checks++;
      if (rb !== 16'h0042 || rbl !== 4'b1100 || lat2 !== 17) begin
         errors++;
         $display("FAIL b2b_second: got %h/%b lat %0d, expected 0042/1100 lat 17",
                  rb, rbl, lat2);
      end
   endtask

   task automatic test_abort();
      logic        saw;
      logic [15:0] rb;
      logic [3:0]  rbl;
      logic        ro;
      int          lat;
      logic        bok;
      in_valid = 1'b1;
      bin      = 16'd500;
      step();
      in_valid = 1'b0;
      repeat (5) step();
      rst      = 1'b1;
      in_valid = 1'b1;
      step();
      rst      = 1'b0;
      in_valid = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || bcd !== 16'h0000 || blank !== 4'b1110
          || ovf !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL abort_state: got rdy=%b %h/%b/%b ov=%b, expected 1 0000/1110/0 0",
                  in_ready, bcd, blank, ovf, out_valid);
      end
      saw = 1'b0;
      repeat (25) begin
         step();
         if (out_valid) saw = 1'b1;
      end
      checks++;
      if (saw !== 1'b0) begin
         errors++;
         $display("FAIL abort_valid: got pulse, expected none");
      end
      convert(16'd321, rb, rbl, ro, lat, bok);
      checks++;
      if (rb !== 16'h0321 || rbl !== 4'b1000 || ro !== 1'b0
          || lat !== 17) begin
         errors++;
         $display("FAIL after_abort: got %h/%b/%b lat %0d, expected 0321/1000/0 lat 17",
                  rb, rbl, ro, lat);
      end
   endtask

   task automatic test_random();
      logic [15:0] v;
      logic [15:0] eb;
      logic [15:0] rb;
      logic [3:0]  rbl;
      logic        ro;
      int          lat;
      logic        bok;
      for (int k = 0; k < 24; k++) begin
         v  = 16'($urandom_range(0, 65535));
         if (k < 12) v = 16'($urandom_range(0, 9999));
         eb = ref_bcd(int'(v));
         convert(v, rb, rbl, ro, lat, bok);
         checks++;
         if (rb !== eb || rbl !== ref_blank(eb)
             || ro !== (v > 16'd9999) || lat !== 17) begin
            errors++;
            $display("FAIL rand_%0d: got %h/%b/%b lat %0d, expected %h/%b/%b lat 17",
                     v, rb, rbl, ro, lat, eb, ref_blank(eb), v > 16'd9999);
         end
      end
   endtask

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      bin      = '0;
      test_reset();
      test_latency();
      test_table();
      test_back_to_back();
      test_abort();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
